// File: rtl/mant_div_seq.sv
// Restoring mantissa divider for the FDIV path.
// Produces one quotient bit per cycle, plus a sticky bit and a divide-by-zero flag.
// out_busy stalls the pipeline while an operation is in flight.
// in_flush aborts the current operation without producing a valid pulse.
module mant_div_seq #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned GRS_W  = 2
) (
    input  logic                       in_Clk,
    input  logic                       in_Rst_N,
    input  logic                       in_start,
    input  logic                       in_flush,
    input  logic [MANT_W-1:0]          in_dividend,
    input  logic [MANT_W-1:0]          in_divisor,
    output logic                       out_busy,
    output logic                       out_load,
    output logic                       out_shift_en,
    output logic                       out_valid,
    output logic [MANT_W+GRS_W-1:0]    out_quot,
    output logic                       out_sticky,
    output logic                       out_div_zero
);

    localparam int unsigned QW = MANT_W + GRS_W;
    localparam int unsigned RW = MANT_W + 1;
    localparam int unsigned CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [MANT_W-1:0] dividend_q;
    logic [MANT_W-1:0] divisor_q;
    logic [RW-1:0]     rem_q;
    logic [QW-1:0]     quot_q;
    logic [CW-1:0]     cnt_q;
    logic              zdiv_q;

    logic [RW:0]       diff_d;
    logic              qbit_d;
    logic [RW-1:0]     keep_d;
    logic [RW-1:0]     rem_d;
    logic [QW-1:0]     quot_d;

    // One restoring step: trial subtract, pick quotient bit, shift remainder.
    always_comb begin
        diff_d = {1'b0, rem_q} - {2'b00, divisor_q};
        qbit_d = ~diff_d[RW];
        keep_d = qbit_d ? diff_d[RW-1:0] : rem_q;
        rem_d  = keep_d << 1;
        quot_d = (quot_q << 1) | QW'(qbit_d);
    end

    // Controller, datapath registers and registered outputs.
    // A zero divisor spends a second LOAD cycle (zdiv_q set) before reporting.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            state_q      <= S_IDLE;
            dividend_q   <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            cnt_q        <= '0;
            zdiv_q       <= 1'b0;
            out_busy     <= 1'b0;
            out_load     <= 1'b0;
            out_shift_en <= 1'b0;
            out_valid    <= 1'b0;
            out_quot     <= '0;
            out_sticky   <= 1'b0;
            out_div_zero <= 1'b0;
        end else if (in_flush) begin
            state_q      <= S_IDLE;
            zdiv_q       <= 1'b0;
            out_busy     <= 1'b0;
            out_load     <= 1'b0;
            out_shift_en <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    out_valid <= 1'b0;
                    if (in_start) begin
                        state_q      <= S_LOAD;
                        dividend_q   <= in_dividend;
                        divisor_q    <= in_divisor;
                        out_busy     <= 1'b1;
                        out_load     <= 1'b1;
                        out_quot     <= '0;
                        out_sticky   <= 1'b0;
                        out_div_zero <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (!zdiv_q) begin
                        rem_q    <= {1'b0, dividend_q};
                        quot_q   <= '0;
                        cnt_q    <= '0;
                        out_load <= 1'b0;
                        if (divisor_q == '0) begin
                            zdiv_q <= 1'b1;
                        end else begin
                            state_q      <= S_ITER;
                            out_shift_en <= 1'b1;
                        end
                    end else begin
                        zdiv_q       <= 1'b0;
                        state_q      <= S_DONE;
                        out_busy     <= 1'b0;
                        out_valid    <= 1'b1;
                        out_quot     <= '1;
                        out_sticky   <= 1'b0;
                        out_div_zero <= 1'b1;
                    end
                end
                S_ITER: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) begin
                        state_q      <= S_DONE;
                        out_shift_en <= 1'b0;
                        out_busy     <= 1'b0;
                        out_valid    <= 1'b1;
                        out_quot     <= quot_d;
                        out_sticky   <= |rem_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mant_div_seq.sv
// Scoreboard bench for mant_div_seq: single-precision and double-precision instances.
module tb_mant_div_seq;

    localparam int unsigned QW24 = 26;
    localparam int unsigned QW53 = 55;

    typedef struct {
        logic [63:0] q;
        logic        st;
        logic        dz;
        longint      cyc;
        int          sh;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic        start24 = 1'b0;
    logic [23:0] dvd24 = '0, dvs24 = '0;
    logic        busy24, load24, shift24, valid24, st24, dz24;
    logic [25:0] quot24;

    logic        start53 = 1'b0;
    logic [52:0] dvd53 = '0, dvs53 = '0;
    logic        busy53, load53, shift53, valid53, st53, dz53;
    logic [54:0] quot53;

    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    exp_t   q24[$];
    exp_t   q53[$];
    int     sh24 = 0, sh53 = 0;
    logic   pv24 = 1'b0, pv53 = 1'b0;

    mant_div_seq #(.MANT_W(24), .GRS_W(2)) u_sp (
        .in_Clk(clk), .in_Rst_N(rst_n), .in_start(start24), .in_flush(flush),
        .in_dividend(dvd24), .in_divisor(dvs24),
        .out_busy(busy24), .out_load(load24), .out_shift_en(shift24), .out_valid(valid24),
        .out_quot(quot24), .out_sticky(st24), .out_div_zero(dz24)
    );

    mant_div_seq #(.MANT_W(53), .GRS_W(2)) u_dp (
        .in_Clk(clk), .in_Rst_N(rst_n), .in_start(start53), .in_flush(1'b0),
        .in_dividend(dvd53), .in_divisor(dvs53),
        .out_busy(busy53), .out_load(load53), .out_shift_en(shift53), .out_valid(valid53),
        .out_quot(quot53), .out_sticky(st53), .out_div_zero(dz53)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: quotient = floor(a * 2^(qw-1) / b), sticky = nonzero remainder.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int qw);
        exp_t        e;
        logic [127:0] n;
        e.cyc = 0;
        e.sh  = 0;
        if (b == 64'd0) begin
            e.q  = (64'd1 << qw) - 64'd1;
            e.st = 1'b0;
            e.dz = 1'b1;
        end else begin
            n    = {64'd0, a} << (qw - 1);
            e.q  = 64'(n / {64'd0, b});
            e.st = (n % {64'd0, b}) != 128'd0;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor for the single-precision instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (load24) sh24 = 0;
            if (shift24) sh24++;
            if (valid24) begin
                chk("sp_valid_pulse", 64'(pv24), 64'd0);
                if (q24.size() == 0) begin
                    chk("sp_spurious_valid", 64'(valid24), 64'd0);
                end else begin
                    e = q24.pop_front();
                    chk("sp_quot", 64'(quot24), e.q);
                    chk("sp_sticky", 64'(st24), 64'(e.st));
                    chk("sp_div_zero", 64'(dz24), 64'(e.dz));
                    chk("sp_latency", 64'(cyc), 64'(e.cyc));
                    chk("sp_shift_cycles", 64'(sh24), 64'(e.sh));
                    chk("sp_busy_in_done", 64'(busy24), 64'd0);
                end
            end else if (q24.size() != 0) begin
                chk("sp_busy_in_flight", 64'(busy24), 64'd1);
            end
            pv24 = valid24;
        end else begin
            sh24 = 0;
            pv24 = 1'b0;
        end
    end

    // Monitor for the double-precision instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (load53) sh53 = 0;
            if (shift53) sh53++;
            if (valid53) begin
                if (q53.size() == 0) begin
                    chk("dp_spurious_valid", 64'(valid53), 64'd0);
                end else begin
                    e = q53.pop_front();
                    chk("dp_quot", 64'(quot53), e.q);
                    chk("dp_sticky", 64'(st53), 64'(e.st));
                    chk("dp_div_zero", 64'(dz53), 64'(e.dz));
                    chk("dp_latency", 64'(cyc), 64'(e.cyc));
                    chk("dp_shift_cycles", 64'(sh53), 64'(e.sh));
                end
            end
            pv53 = valid53;
        end else begin
            sh53 = 0;
            pv53 = 1'b0;
        end
    end

    // Present a start at the current negedge; returns just after the accepting edge.
    task automatic issue(input bit sel, input logic [63:0] a, input logic [63:0] b, input bit push);
        exp_t e;
        int   qw;
        qw = sel ? int'(QW53) : int'(QW24);
        if (sel) begin
            start53 = 1'b1; dvd53 = a[52:0]; dvs53 = b[52:0];
        end else begin
            start24 = 1'b1; dvd24 = a[23:0]; dvs24 = b[23:0];
        end
        @(posedge clk);
        #1;
        start24 = 1'b0;
        start53 = 1'b0;
        if (push) begin
            e     = model(a, b, qw);
            e.cyc = cyc + ((b == 64'd0) ? 2 : qw + 1);
            e.sh  = (b == 64'd0) ? 0 : qw;
            if (sel) q53.push_back(e);
            else     q24.push_back(e);
        end
        if (!sel) begin
            chk("sp_accept_busy", 64'(busy24), 64'd1);
            chk("sp_accept_load", 64'(load24), 64'd1);
            chk("sp_accept_quot_cleared", 64'(quot24), 64'd0);
            chk("sp_accept_dz_cleared", 64'(dz24), 64'd0);
        end
    endtask

    // Advance negedge by negedge until valid is seen; ends at the negedge of the DONE cycle.
    task automatic wait_valid(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = sel ? valid53 : valid24;
        end
        if (!seen) chk(sel ? "dp_valid_timeout" : "sp_valid_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] rnd_mant(input int w);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v = v & ((64'd1 << (w - 1)) - 64'd1);
        return v | (64'd1 << (w - 1));
    endfunction

    initial begin
        logic [63:0] a, b;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy24), 64'd0);
        chk("rst_valid", 64'(valid24), 64'd0);
        chk("rst_quot", 64'(quot24), 64'd0);
        chk("rst_flags", 64'({load24, shift24, st24, dz24}), 64'd0);
        chk("rst_dp_quot", 64'(quot53), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1.5 / 1.0
        issue(0, 64'hC00000, 64'h800000, 1);
        wait_valid(0);
        @(negedge clk);
        chk("sp_hold_quot", 64'(quot24), 64'h3000000);
        chk("sp_hold_valid_low", 64'(valid24), 64'd0);

        // 1.0 / 1.5 -> repeating 01 pattern, sticky set
        @(negedge clk);
        issue(0, 64'h800000, 64'hC00000, 1);
        wait_valid(0);
        chk("sp_two_thirds", 64'(quot24), 64'h1555555);

        // Divide by zero
        @(negedge clk);
        issue(0, 64'h900000, 64'd0, 1);
        wait_valid(0);
        chk("sp_dz_quot", 64'(quot24), 64'h3FFFFFF);

        // Flush on the 10th ITER cycle: no valid, busy drops next cycle
        @(negedge clk);
        issue(0, 64'hC00000, 64'h800000, 0);
        repeat (11) @(negedge clk);
        chk("sp_pre_flush_shift", 64'(shift24), 64'd1);
        flush = 1'b1;
        start24 = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start24 = 1'b0;
        chk("sp_flush_busy", 64'(busy24), 64'd0);
        chk("sp_flush_shift", 64'(shift24), 64'd0);
        chk("sp_flush_load", 64'(load24), 64'd0);
        repeat (40) @(negedge clk);
        issue(0, 64'hC00000, 64'h800000, 1);
        wait_valid(0);

        // Back-to-back start from DONE, with starts during ITER ignored
        @(negedge clk);
        issue(0, 64'hF12345, 64'h876543, 1);
        wait_valid(0);
        issue(0, 64'hA5A5A5, 64'hFFFFFF, 1);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            start24 = 1'b1;
            dvd24 = 24'h800001;
            dvs24 = 24'h000000;
            @(negedge clk);
            start24 = 1'b0;
            repeat (2) @(negedge clk);
        end
        wait_valid(0);

        // Random normalised operands
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            a = rnd_mant(24);
            b = ($urandom_range(0, 9) == 0) ? 64'd0 : rnd_mant(24);
            issue(0, a, b, 1);
            wait_valid(0);
        end

        // Asynchronous reset mid-ITER
        @(negedge clk);
        issue(0, 64'hC00000, 64'hA00000, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy24), 64'd0);
        chk("arst_shift", 64'(shift24), 64'd0);
        chk("arst_quot", 64'(quot24), 64'd0);
        chk("arst_flags", 64'({load24, valid24, st24, dz24}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (35) @(negedge clk);

        // Double precision: 1.5 / 1.0 and random
        issue(1, 64'h18000000000000, 64'h10000000000000, 1);
        wait_valid(1);
        chk("dp_three_halves", 64'(quot53), 64'h60000000000000);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            issue(1, rnd_mant(53), rnd_mant(53), 1);
            wait_valid(1);
        end

        repeat (5) @(negedge clk);
        chk("sp_queue_drained", 64'(q24.size()), 64'd0);
        chk("dp_queue_drained", 64'(q53.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
